// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// holds the returned {pc, instruction} in a single output register for decode.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Request valid never depends on imem_req_ready; if_valid never depends on if_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic        out_free;
  logic        req_valid;
  logic        req_fire;
  logic [31:0] redirect_target;

  always_comb begin
    out_free        = !if_valid_q || if_ready;
    req_valid       = (state_q == S_REQ) && out_free;
    req_fire        = req_valid && imem_req_ready;
    redirect_target = redirect_pc & ~32'd3;

    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (if_valid_q && if_ready) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
      end

      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
        end
        // A request accepted alongside a redirect carries the old pc, so its
        // response must be thrown away when it returns.
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
          if (req_fire) begin
            discard_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
          if (!discard_q && !redirect_valid) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
          end
        end
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
          if (!imem_rsp_valid) begin
            discard_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC & ~32'd3;
      discard_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'd0;
      if_pc_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instruction = if_instr_q;
  assign if_pc          = if_pc_q;

  // A stalled instruction must stay put until decode takes it or a redirect kills it.
  hold_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
    (if_valid_q && !if_ready && !redirect_valid) |=>
      (if_valid_q && $stable(if_instr_q) && $stable(if_pc_q)));

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch with a small in-order instruction memory model.
module tb_cpu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;

  int total = 0;
  int bad = 0;
  int mem_lat = 1;
  int fire_cnt = 0;
  logic [31:0] last_fire = 32'd0;

  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hDEAD_BEEF;
  endfunction

  cpu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // memory model: one response per accepted request after mem_lat cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend           <= 1'b0;
      pend_cnt       <= 0;
      pend_addr      <= 32'd0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'd0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (pend) begin
        if (pend_cnt <= 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= mem_word(pend_addr);
          pend           <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        if (mem_lat <= 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= mem_word(imem_req_addr);
        end else begin
          pend      <= 1'b1;
          pend_cnt  <= mem_lat - 1;
          pend_addr <= imem_req_addr;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      fire_cnt  <= fire_cnt + 1;
      last_fire <= imem_req_addr;
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat, input logic ifr, input logic mrdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if_ready       = ifr;
    imem_req_ready = mrdy;
    mem_lat        = lat;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0b want=0", imem_req_valid); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%0b want=0", if_valid); end
    total++; if (if_pc !== 32'd0) begin bad++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
    total++; if (if_instruction !== 32'd0) begin bad++; $display("FAIL rst_if_instr got=%h want=0", if_instruction); end
    total++; if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL rst_pc got=%h want=%h", imem_req_addr, RST_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_q[$];
    do_reset(1, 1'b1, 1'b1);
    exp_q = '{32'h100, 32'h104, 32'h108};
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_q[0]) begin bad++; $display("FAIL seq_req0 got=%0b/%h want=1/%h", imem_req_valid, imem_req_addr, exp_q[0]); end
    for (int k = 1; k < 3; k++) begin
      step();
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL seq_gap%0d got=%0b want=0", k, imem_req_valid); end
      step();
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_q[k]) begin bad++; $display("FAIL seq_req%0d got=%0b/%h want=1/%h", k, imem_req_valid, imem_req_addr, exp_q[k]); end
      total++; if (if_valid !== 1'b1 || if_pc !== exp_q[k-1]) begin bad++; $display("FAIL seq_out%0d got=%0b/%h want=1/%h", k, if_valid, if_pc, exp_q[k-1]); end
      total++; if (if_instruction !== mem_word(exp_q[k-1])) begin bad++; $display("FAIL seq_instr%0d got=%h want=%h", k, if_instruction, mem_word(exp_q[k-1])); end
    end
  endtask

  task automatic test_decode_stall();
    do_reset(1, 1'b0, 1'b1);
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin bad++; $display("FAIL stall_hold%0d got=%0b/%h want=1/00000100", i, if_valid, if_pc); end
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_noreq%0d got=%0b want=0", i, imem_req_valid); end
      step();
    end
    if_ready = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin bad++; $display("FAIL stall_resume got=%0b/%h want=1/00000104", imem_req_valid, imem_req_addr); end
    step();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b want=0", if_valid); end
    step();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin bad++; $display("FAIL stall_next got=%0b/%h want=1/00000104", if_valid, if_pc); end
  endtask

  task automatic test_mem_backpressure();
    int base;
    do_reset(1, 1'b1, 1'b0);
    base = fire_cnt;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL bp_hold%0d got=%0b/%h want=1/00000100", i, imem_req_valid, imem_req_addr); end
    end
    total++; if (fire_cnt !== base) begin bad++; $display("FAIL bp_nofire got=%0d want=%0d", fire_cnt - base, 0); end
    imem_req_ready = 1'b1;
    step();
    total++; if (fire_cnt !== base + 1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_single got=%0d/%0b want=1/0", fire_cnt - base, imem_req_valid); end
    step();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin bad++; $display("FAIL bp_out got=%0b/%h want=1/00000100", if_valid, if_pc); end
  endtask

  task automatic test_redirect_idle();
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0602;
    rst_n          = 1'b1;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h600) begin bad++; $display("FAIL idle_redir got=%0b/%h want=1/00000600", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    logic found;
    do_reset(3, 1'b1, 1'b1);
    step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    step();
    redirect_valid = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_wait got=%0b/%0b want=0/0", if_valid, imem_req_valid); end
    step(); step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin bad++; $display("FAIL rw_req got=%0b/%h want=1/00002000", imem_req_valid, imem_req_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rw_stale got=%0b want=0", if_valid); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (if_valid) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rw_timeout got=0 want=1"); end
    else begin
      total++; if (if_pc !== 32'h2000 || if_instruction !== mem_word(32'h2000)) begin bad++; $display("FAIL rw_out got=%h/%h want=00002000/%h", if_pc, if_instruction, mem_word(32'h2000)); end
    end
  endtask

  task automatic test_redirect_handshake();
    logic found;
    do_reset(1, 1'b1, 1'b1);
    step(); step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    total++; if (last_fire !== 32'h104 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL rh_issue got=%h/%0b/%0b want=00000104/0/0", last_fire, imem_req_valid, if_valid); end
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000 || if_valid !== 1'b0) begin bad++; $display("FAIL rh_next got=%0b/%h/%0b want=1/00003000/0", imem_req_valid, imem_req_addr, if_valid); end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (if_valid) found = 1'b1;
    end
    total++; if (!found || if_pc !== 32'h3000 || if_instruction !== mem_word(32'h3000)) begin bad++; $display("FAIL rh_out got=%0b/%h/%h want=1/00003000/%h", found, if_pc, if_instruction, mem_word(32'h3000)); end
  endtask

  task automatic test_redirect_stall_wrap();
    do_reset(1, 1'b0, 1'b1);
    step(); step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL wrap_kill got=%0b want=0", if_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%0b/%h want=1/fffffffc", imem_req_valid, imem_req_addr); end
    step(); step();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instruction !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_out got=%0b/%h/%h want=1/fffffffc/%h", if_valid, if_pc, if_instruction, mem_word(32'hFFFF_FFFC)); end
    if_ready = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%0b/%h want=1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_back_to_back();
    logic found;
    do_reset(3, 1'b1, 1'b1);
    step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    step();
    redirect_pc    = 32'h0000_5000;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL b2b_wait got=%0b/%0b want=0/0", imem_req_valid, if_valid); end
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h5000) begin bad++; $display("FAIL b2b_req got=%0b/%h want=1/00005000", imem_req_valid, imem_req_addr); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (if_valid) found = 1'b1;
    end
    total++; if (!found || if_pc !== 32'h5000 || if_instruction !== mem_word(32'h5000)) begin bad++; $display("FAIL b2b_out got=%0b/%h/%h want=1/00005000/%h", found, if_pc, if_instruction, mem_word(32'h5000)); end
  endtask

  task automatic test_reset_mid();
    logic found;
    do_reset(1, 1'b0, 1'b1);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instruction !== 32'd0) begin bad++; $display("FAIL mid_clear got=%0b/%h/%h want=0/0/0", if_valid, if_pc, if_instruction); end
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin bad++; $display("FAIL mid_req got=%0b/%h want=0/%h", imem_req_valid, imem_req_addr, RST_PC); end
    do_reset(3, 1'b1, 1'b1);
    step(); step();
    rst_n = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_wait got=%0b want=0", imem_req_valid); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL mid_restart got=%0b/%h want=1/00000100", imem_req_valid, imem_req_addr); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if_valid) found = 1'b1;
    end
    total++; if (!found || if_pc !== 32'h100) begin bad++; $display("FAIL mid_out got=%0b/%h want=1/00000100", found, if_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_decode_stall();
    test_mem_backpressure();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_handshake();
    test_redirect_stall_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
